alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_core.sv | 82 ++++++++
 rtl/alu_seq.sv | 134 +++++++++++++
 tb/tb_alu_seq.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 6-bit opcode encodings of the supported operations
//   - FSM state encoding used by alu_seq
//   - bit positions of the {N,Z,C,V} flags in o_flags
//   - index of each button in i_enable
package alu_pkg;

   localparam int OPC_W = 6;

   localparam logic [OPC_W-1:0] OPC_ADD = 6'b100000;
   localparam logic [OPC_W-1:0] OPC_SUB = 6'b100010;
   localparam logic [OPC_W-1:0] OPC_AND = 6'b100100;
   localparam logic [OPC_W-1:0] OPC_OR  = 6'b100101;
   localparam logic [OPC_W-1:0] OPC_XOR = 6'b100110;
   localparam logic [OPC_W-1:0] OPC_NOR = 6'b100111;
   localparam logic [OPC_W-1:0] OPC_SRL = 6'b000010;
   localparam logic [OPC_W-1:0] OPC_SRA = 6'b000011;
   localparam logic [OPC_W-1:0] OPC_SLL = 6'b000000;
   localparam logic [OPC_W-1:0] OPC_SLT = 6'b101010;

   typedef enum logic [2:0] {
      S_OP1   = 3'd0,
      S_OPC   = 3'd1,
      S_OP2   = 3'd2,
      S_READY = 3'd3,
      S_EXEC  = 3'd4
   } state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int BTN_OP1 = 0;
   localparam int BTN_OPC = 1;
   localparam int BTN_OP2 = 2;
   localparam int BTN_EXE = 3;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: switch/button inputs and result outputs of the sequential ALU.
//   i_switch  : operand / opcode data
//   i_enable  : button levels ([0] op1, [1] opcode, [2] op2, [3] execute)
//   o_leds    : registered result
//   o_flags   : registered {N,Z,C,V}
//   o_valid   : one-cycle pulse when o_leds/o_flags update
//   o_error   : last loaded opcode was unsupported
//   o_busy    : execute cycle in progress
// master = stimulus side, slave = the ALU.
interface alu_seq_if #(
   parameter int N_BITS = 8,
   parameter int N_BTN  = 4
);
   logic [N_BITS-1:0] i_switch;
   logic [N_BTN-1:0]  i_enable;
   logic [N_BITS-1:0] o_leds;
   logic [3:0]        o_flags;
   logic              o_valid;
   logic              o_error;
   logic              o_busy;

   modport master (
      output i_switch, i_enable,
      input  o_leds, o_flags, o_valid, o_error, o_busy
   );

   modport slave (
      input  i_switch, i_enable,
      output o_leds, o_flags, o_valid, o_error, o_busy
   );
endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational arithmetic/logic unit.
//   op1, op2  : two's complement operands (N_BITS)
//   opcode    : 6-bit operation code
//   result    : N_BITS result, truncated
//   flags     : {N,Z,C,V}
//   supported : opcode is one of the implemented operations
module alu_core
   import alu_pkg::*;
#(
   parameter int N_BITS = 8
) (
   input  logic signed [N_BITS-1:0] op1,
   input  logic signed [N_BITS-1:0] op2,
   input  logic [OPC_W-1:0]         opcode,
   output logic signed [N_BITS-1:0] result,
   output logic [3:0]               flags,
   output logic                     supported
);

   localparam int MSB = N_BITS - 1;
   localparam logic [N_BITS-1:0] SHIFT_LIMIT = N_BITS'(N_BITS);

   logic [N_BITS:0]   sum;
   logic [N_BITS-1:0] amt;
   logic              big_shift;
   logic              carry;
   logic              ovf;

   // Shift amount is op2 read as unsigned; anything >= width saturates.
   assign amt       = $unsigned(op2);
   assign big_shift = (amt >= SHIFT_LIMIT);

   // Shifts use if/else rather than ?: so an unsigned '0 arm cannot turn
   // the arithmetic shift into a logical one.
   always_comb begin
      sum       = '0;
      result    = '0;
      carry     = 1'b0;
      ovf       = 1'b0;
      supported = 1'b1;
      case (opcode)
         OPC_ADD: begin
            sum    = {1'b0, op1} + {1'b0, op2};
            result = sum[N_BITS-1:0];
            carry  = sum[N_BITS];
            ovf    = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]);
         end
         OPC_SUB: begin
            result = op1 - op2;
            carry  = ($unsigned(op1) < $unsigned(op2));
            ovf    = (op1[MSB] != op2[MSB]) && (result[MSB] != op1[MSB]);
         end
         OPC_AND: result = op1 & op2;
         OPC_OR:  result = op1 | op2;
         OPC_XOR: result = op1 ^ op2;
         OPC_NOR: result = ~(op1 | op2);
         OPC_SRL: begin
            if (big_shift) result = '0;
            else           result = $signed($unsigned(op1) >> amt);
         end
         OPC_SRA: begin
            if (big_shift) result = {N_BITS{op1[MSB]}};
            else           result = op1 >>> amt;
         end
         OPC_SLL: begin
            if (big_shift) result = '0;
            else           result = op1 << amt;
         end
         OPC_SLT: result = {{(N_BITS-1){1'b0}}, (op1 < op2)};
         default: supported = 1'b0;
      endcase
   end

   always_comb begin
      flags         = 4'b0000;
      flags[FLAG_N] = result[MSB];
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_C] = carry;
      flags[FLAG_V] = ovf;
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: button-driven sequential ALU.
//   i_clock : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : alu_seq_if slave (switches, buttons, result/flag/status outputs)
// Buttons are edge-detected; an FSM walks op1 -> opcode -> op2 -> ready,
// and each execute press runs one S_EXEC cycle that registers the result.
module alu_seq
   import alu_pkg::*;
#(
   parameter int N_BITS = 8,
   parameter int N_BTN  = 4
) (
   input  logic     i_clock,
   input  logic     i_reset,
   alu_seq_if.slave bus
);

   state_t                   state_q, state_d;
   logic [N_BTN-1:0]         en_d1, en_d2, rise, ev;
   logic signed [N_BITS-1:0] op1_q, op2_q, core_result;
   logic [OPC_W-1:0]         opcode_q, core_opcode;
   logic [3:0]               core_flags;
   logic                     core_supported;
   logic [N_BITS-1:0]        leds_q;
   logic [3:0]               flags_q;
   logic                     valid_q, error_q;
   logic                     ld_op1, ld_opc, ld_op2, set_err, do_exec;

   // Rising edges; more than one in the same cycle cancels them all.
   assign rise = en_d1 & ~en_d2;
   assign ev   = ((rise & (rise - 1'b1)) == '0) ? rise : '0;

   // While waiting for an opcode the core checks the switches directly, so
   // an unsupported code is caught before it overwrites opcode_q.
   assign core_opcode = (state_q == S_OPC) ? bus.i_switch[OPC_W-1:0] : opcode_q;

   alu_core #(.N_BITS(N_BITS)) u_core (
      .op1       (op1_q),
      .op2       (op2_q),
      .opcode    (core_opcode),
      .result    (core_result),
      .flags     (core_flags),
      .supported (core_supported)
   );

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         en_d1 <= '0;
         en_d2 <= '0;
      end else begin
         en_d1 <= bus.i_enable;
         en_d2 <= en_d1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) state_q <= S_OP1;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ld_op1  = 1'b0;
      ld_opc  = 1'b0;
      ld_op2  = 1'b0;
      set_err = 1'b0;
      do_exec = 1'b0;
      case (state_q)
         S_OP1: begin
            if (ev[BTN_OP1]) begin
               ld_op1  = 1'b1;
               state_d = S_OPC;
            end
         end
         S_OPC: begin
            if (ev[BTN_OPC]) begin
               if (core_supported) begin
                  ld_opc  = 1'b1;
                  state_d = S_OP2;
               end else begin
                  set_err = 1'b1;
               end
            end
         end
         S_OP2: begin
            if (ev[BTN_OP2]) begin
               ld_op2  = 1'b1;
               state_d = S_READY;
            end
         end
         S_READY: begin
            if (ev[BTN_EXE])      state_d = S_EXEC;
            else if (ev[BTN_OP1]) ld_op1  = 1'b1;
         end
         S_EXEC: begin
            do_exec = 1'b1;
            state_d = S_READY;
         end
         default: state_d = S_OP1;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         op1_q    <= '0;
         op2_q    <= '0;
         opcode_q <= '0;
         leds_q   <= '0;
         flags_q  <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         valid_q <= do_exec;
         if (ld_op1) op1_q <= bus.i_switch;
         if (ld_op2) op2_q <= bus.i_switch;
         if (ld_opc) begin
            opcode_q <= bus.i_switch[OPC_W-1:0];
            error_q  <= 1'b0;
         end
         if (set_err) error_q <= 1'b1;
         if (do_exec) begin
            leds_q  <= core_result;
            flags_q <= core_flags;
         end
      end
   end

   assign bus.o_leds  = leds_q;
   assign bus.o_flags = flags_q;
   assign bus.o_valid = valid_q;
   assign bus.o_error = error_q;
   assign bus.o_busy  = (state_q == S_EXEC);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (N_BITS = 8).
module tb_alu_seq;
   import alu_pkg::*;

   logic i_clock = 1'b0;
   logic i_reset = 1'b1;
   int   checks  = 0;
   int   errors  = 0;
   int   pulses;

   alu_seq_if #(.N_BITS(8), .N_BTN(4)) bus ();

   alu_seq #(.N_BITS(8), .N_BTN(4)) dut (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input state_t exp);
      chk(tag, 32'(dut.state_q), 32'(exp));
   endtask

   // Drive one button pattern for one cycle, then wait one idle cycle so the
   // FSM has acted on the event.
   task automatic press(input logic [3:0] mask, input logic [7:0] sw);
      @(negedge i_clock);
      bus.i_switch = sw;
      bus.i_enable = mask;
      @(negedge i_clock);
      bus.i_enable = 4'b0000;
      @(negedge i_clock);
   endtask

   // Hold a button pattern for n cycles, counting o_valid pulses seen.
   task automatic hold(input logic [3:0] mask, input logic [7:0] sw, input int n,
                       output int cnt);
      cnt = 0;
      @(negedge i_clock);
      bus.i_switch = sw;
      bus.i_enable = mask;
      repeat (n) begin
         @(negedge i_clock);
         if (bus.o_valid) cnt++;
      end
      bus.i_enable = 4'b0000;
   endtask

   task automatic do_reset();
      @(negedge i_clock);
      i_reset = 1'b0;
      @(negedge i_clock);
      i_reset = 1'b1;
   endtask

   task automatic load3(input logic [7:0] a, input logic [7:0] opc, input logic [7:0] b);
      press(4'b0001, a);
      press(4'b0010, opc);
      press(4'b0100, b);
   endtask

   // Execute press: busy two negedges later, o_valid exactly one cycle after.
   task automatic execute(input string tag, input logic [7:0] exp_leds,
                          input logic [3:0] exp_flags);
      @(negedge i_clock);
      bus.i_enable = 4'b1000;
      @(negedge i_clock);
      bus.i_enable = 4'b0000;
      @(negedge i_clock);
      chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
      chk({tag, "_early_valid"}, 32'(bus.o_valid), 32'd0);
      @(negedge i_clock);
      chk({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
      chk({tag, "_leds"}, 32'(bus.o_leds), 32'(exp_leds));
      chk({tag, "_flags"}, 32'(bus.o_flags), 32'(exp_flags));
      @(negedge i_clock);
      chk({tag, "_valid_drop"}, 32'(bus.o_valid), 32'd0);
      chk({tag, "_leds_hold"}, 32'(bus.o_leds), 32'(exp_leds));
      chk_state({tag, "_ready"}, S_READY);
   endtask

   initial begin
      bus.i_switch = 8'h00;
      bus.i_enable = 4'b0000;

      // Reset state
      #1 i_reset = 1'b0;
      @(negedge i_clock);
      chk("rst_leds",  32'(bus.o_leds),  32'h00);
      chk("rst_flags", 32'(bus.o_flags), 32'h0);
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_error", 32'(bus.o_error), 32'd0);
      chk("rst_busy",  32'(bus.o_busy),  32'd0);
      chk_state("rst_state", S_OP1);
      @(negedge i_clock);
      i_reset = 1'b1;

      // Op2 button in S_OP1 is ignored
      press(4'b0100, 8'h11);
      chk_state("op2_in_op1", S_OP1);

      // 0x7F + 0x01 -> 0x80, N=1 V=1
      load3(8'h7F, 8'h20, 8'h01);
      chk_state("add_loaded", S_READY);
      execute("add", 8'h80, 4'b1001);
      repeat (3) @(negedge i_clock);
      chk("add_hold_leds",  32'(bus.o_leds),  32'h80);
      chk("add_hold_flags", 32'(bus.o_flags), 32'h9);

      // 0x00 - 0x01 -> 0xFF with borrow; repeat with op1 = 0x01 -> zero
      do_reset();
      load3(8'h00, 8'h22, 8'h01);
      execute("sub", 8'hFF, 4'b1010);
      press(4'b0001, 8'h01);
      chk_state("repeat_stays_ready", S_READY);
      execute("sub_rep", 8'h00, 4'b0100);

      // Shifts, including saturation of an oversized amount
      do_reset();
      load3(8'h90, 8'h03, 8'h09);
      execute("sra9", 8'hFF, 4'b1000);
      do_reset();
      load3(8'h90, 8'h02, 8'h02);
      execute("srl2", 8'h24, 4'b0000);
      do_reset();
      load3(8'h01, 8'h00, 8'h08);
      execute("sll8", 8'h00, 4'b0100);

      // Unsupported opcode then a good one
      do_reset();
      press(4'b0001, 8'h05);
      press(4'b0010, 8'h3F);
      chk("bad_opc_err", 32'(bus.o_error), 32'd1);
      chk_state("bad_opc_state", S_OPC);
      press(4'b0010, 8'h20);
      chk("good_opc_err", 32'(bus.o_error), 32'd0);
      chk_state("good_opc_state", S_OP2);
      press(4'b0100, 8'h03);
      execute("add_after_err", 8'h08, 4'b0000);

      // Simultaneous edges ignored; held buttons give one event
      do_reset();
      press(4'b0101, 8'h03);
      chk_state("dual_edge_ignored", S_OP1);
      hold(4'b0001, 8'h03, 10, pulses);
      @(negedge i_clock);
      chk_state("held_op1_once", S_OPC);
      press(4'b0010, 8'h24);
      press(4'b0100, 8'h06);
      hold(4'b1000, 8'hAA, 10, pulses);
      chk("held_exe_pulses", 32'(pulses), 32'd1);
      chk("held_exe_leds", 32'(bus.o_leds), 32'h02);
      chk_state("held_exe_ready", S_READY);

      // Signed set-less-than
      do_reset();
      load3(8'hFF, 8'h2A, 8'h01);
      execute("slt_true", 8'h01, 4'b0000);
      press(4'b0001, 8'h02);
      execute("slt_false", 8'h00, 4'b0100);

      // Reset during S_EXEC
      do_reset();
      load3(8'h7F, 8'h20, 8'h01);
      execute("pre_rst", 8'h80, 4'b1001);
      @(negedge i_clock);
      bus.i_enable = 4'b1000;
      @(negedge i_clock);
      bus.i_enable = 4'b0000;
      @(negedge i_clock);
      chk("exec_rst_busy_before", 32'(bus.o_busy), 32'd1);
      i_reset = 1'b0;
      #1;
      chk("exec_rst_leds",  32'(bus.o_leds),  32'h00);
      chk("exec_rst_flags", 32'(bus.o_flags), 32'h0);
      chk("exec_rst_valid", 32'(bus.o_valid), 32'd0);
      chk("exec_rst_busy",  32'(bus.o_busy),  32'd0);
      chk_state("exec_rst_state", S_OP1);
      @(negedge i_clock);
      chk("exec_rst_no_valid", 32'(bus.o_valid), 32'd0);
      i_reset = 1'b1;
      @(negedge i_clock);
      chk_state("exec_rst_resume", S_OP1);
      chk("exec_rst_valid_after", 32'(bus.o_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
